mfc_time_set_ctrl: RTL and testbench
====================================

// Module: mfc_time_set_ctrl
// PURPOSE
//  Sequences the clock-set function of the multi-function clock (MFC_top).
//  - Captures the live hh:mm:ss from the timekeeper into a shadow copy.
//  - Moves an edit cursor over the hour/min/sec fields.
//  - Applies up/down edits with modular wrap.
//  - Commits the shadow back to the timekeeper with a one-cycle load strobe when set mode exits.
//  - Sits between the button debouncers / SPDT[14] synchroniser and the timekeeper/display mux.
// PARAMETERS
//  BLINK_DIV    50_000_000     MCLK cycles per blink half-period (0.5 s at 100 MHz)
//  TIMEOUT_CYC  1_000_000_000  idle MCLK cycles before edit abort (only with MFC_SET_TIMEOUT_EN)
//  HOUR_MOD     24             hour modulus (hours run 0..HOUR_MOD-1)
// PORTS
//  MCLK       in   1  system clock, 100 MHz
//  RST        in   1  asynchronous, active-high reset
//  set_en     in   1  clock-set mode request (synchronised SPDT[14]), level
//  btn_up     in   1  debounced 1-cycle pulse: increment selected field
//  btn_down   in   1  debounced 1-cycle pulse: decrement selected field
//  btn_left   in   1  debounced 1-cycle pulse: cursor left
//  btn_right  in   1  debounced 1-cycle pulse: cursor right
//  cur_hour   in   5  live hour from timekeeper
//  cur_min    in   6  live minute from timekeeper
//  cur_sec    in   6  live second from timekeeper
//  edit_hour  out  5  shadow hour (valid when set_active)
//  edit_min   out  6  shadow minute
//  edit_sec   out  6  shadow second
//  cursor     out  2  0=hour 1=min 2=sec (3 never driven)
//  blink      out  1  blank-selected-field phase for display
//  set_active out  1  display must show edit_* instead of cur_*
//  load       out  1  1-cycle strobe: timekeeper loads edit_*
// BEHAVIOUR
//  Reset values
//  - state=IDLE; edit_*=0; cursor=0; blink=0; set_active=0; load=0; counters=0.
//  - RST asserted in any state forces IDLE asynchronously; no load is issued.
//  States
//  - IDLE: set_active=0; all buttons ignored. set_en==1 -> CAPTURE.
//  - CAPTURE (1 cycle): edit_* <= cur_*, cursor <= 0, blink counter cleared -> EDIT.
//  - EDIT: set_active=1. set_en==0 -> COMMIT (button pulses in that same cycle are ignored).
//  - COMMIT (1 cycle): load=1 with edit_* stable -> IDLE. Load appears 2 cycles after set_en samples 0.
//  EDIT arithmetic (all buttons)
//  - up: field = (field==MAX) ? 0 : field+1.
//  - down: field = (field==0) ? MAX : field-1.
//  - MAX = HOUR_MOD-1 for hours, 59 for min/sec.
//  - btn_up and btn_down in the same cycle: no change.
//  - right: cursor 0->1->2->0. left: cursor 0->2->1->0.
//  - btn_left and btn_right in the same cycle: no change.
//  - Up/down and cursor pulses in the same cycle: the edit applies to the old cursor; the cursor then moves.
//  blink
//  - Toggles every BLINK_DIV cycles while in EDIT.
//  - Forced to 0 for BLINK_DIV cycles after any accepted up/down, so the edited value stays visible.
//  - 0 outside EDIT.
//  Shadow
//  - Never updated from cur_* after CAPTURE; the timekeeper keeps running underneath.
// CONFIGURATION
//  MFC_SET_TIMEOUT_EN defined
//  - An idle counter runs in EDIT and clears on any button pulse.
//  - On reaching TIMEOUT_CYC: go to ABORT (set_active=0, no load) and stay until set_en==0, then IDLE.
//  - The live time is kept and the edit is discarded.
//  MFC_SET_TIMEOUT_EN undefined
//  - No ABORT state and no idle counter; EDIT persists until set_en falls.
// STRUCTURE
//  - mfc_pkg: state encoding (IDLE/CAPTURE/EDIT/COMMIT/ABORT), cursor constants FLD_HOUR/FLD_MIN/FLD_SEC, MIN_SEC_MAX=59.
//  - Sub-module mfc_blink_gen (parameter BLINK_DIV): holds the blink counter, with a clr input (CAPTURE/edit) and an en input (EDIT).
//  - FSM and field arithmetic stay in this module.
// TESTING  (bench overrides BLINK_DIV=8, TIMEOUT_CYC=64)
//  1. RST=1 for 3 cycles, then 0 -> all outputs 0; button pulses in IDLE -> edit_*, cursor unchanged.
//  2. cur=23:59:58, set_en 0->1 -> edit=23:59:58, cursor=0. btn_up -> edit_hour=0. btn_down -> 23.
//  3. right x2, btn_up at sec=59 -> sec=0. right again -> cursor=0. left from 0 -> cursor=2.
//  4. Edit to 12:34:00, set_en->0 -> exactly one load pulse, 2 cycles later, with edit=12:34:00; then set_active=0.
//  5. btn_up+btn_down in the same cycle -> no change. RST mid-EDIT -> IDLE, load never asserted.
//  6. MFC_SET_TIMEOUT_EN: 64 idle cycles in EDIT -> set_active=0, no load even after set_en falls. Without the macro -> still EDIT.

Source files
------------

// File: rtl/mfc_pkg.sv
// Shared encodings and edit arithmetic for the clock-set controller.
package mfc_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_EDIT    = 3'd2;
  localparam logic [2:0] ST_COMMIT  = 3'd3;
  localparam logic [2:0] ST_ABORT   = 3'd4;

  localparam logic [1:0] FLD_HOUR = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_SEC  = 2'd2;

  localparam int MIN_SEC_MAX = 59;

  function automatic int wrap_step(input int v, input int mx, input logic up);
    if (up) return (v == mx) ? 0 : v + 1;
    return (v == 0) ? mx : v - 1;
  endfunction

  function automatic logic [1:0] cursor_step(input logic [1:0] c, input logic right);
    if (right) return (c == FLD_SEC) ? FLD_HOUR : c + 2'd1;
    return (c == FLD_HOUR) ? FLD_SEC : c - 2'd1;
  endfunction

endpackage

// File: rtl/mfc_time_set_ctrl_if.sv
// Button/time inputs and shadow-time outputs of the clock-set controller.
interface mfc_time_set_ctrl_if;
  logic       set_en;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] edit_hour;
  logic [5:0] edit_min;
  logic [5:0] edit_sec;
  logic [1:0] cursor;
  logic       blink;
  logic       set_active;
  logic       load;

  modport master (
    output set_en, btn_up, btn_down, btn_left, btn_right, cur_hour, cur_min, cur_sec,
    input  edit_hour, edit_min, edit_sec, cursor, blink, set_active, load
  );

  modport slave (
    input  set_en, btn_up, btn_down, btn_left, btn_right, cur_hour, cur_min, cur_sec,
    output edit_hour, edit_min, edit_sec, cursor, blink, set_active, load
  );
endinterface

// File: rtl/mfc_blink_gen.sv
// Blink phase generator: toggles every BLINK_DIV enabled cycles, clr restarts in the dark phase.
module mfc_blink_gen #(
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic blink
);
  localparam int CW = $clog2(BLINK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    cnt_d   = '0;
    blink_d = 1'b0;
    if (!clr && en) begin
      if (cnt_q == CW'(BLINK_DIV - 1)) begin
        blink_d = ~blink_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
endmodule

// File: rtl/mfc_time_set_ctrl.sv
// Clock-set sequencer: capture live time, edit a shadow copy, commit with a load strobe.
// Optional edit timeout/abort is built when MFC_SET_TIMEOUT_EN is defined.
module mfc_time_set_ctrl
  import mfc_pkg::*;
#(
  parameter int BLINK_DIV   = 50_000_000,
  parameter int TIMEOUT_CYC = 1_000_000_000,
  parameter int HOUR_MOD    = 24
) (
  input  logic                 MCLK,
  input  logic                 RST,
  mfc_time_set_ctrl_if.slave   bus
);
  logic [2:0] state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [1:0] cursor_q, cursor_d;
  logic       load_q, load_d;
  logic       accept;
  logic       blink_raw;

`ifdef MFC_SET_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          btn_any;
  assign btn_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
`endif

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    cursor_d = cursor_q;
    accept   = 1'b0;
`ifdef MFC_SET_TIMEOUT_EN
    idle_d   = '0;
`endif
    case (state_q)
      ST_IDLE: if (bus.set_en) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        hour_d   = bus.cur_hour;
        min_d    = bus.cur_min;
        sec_d    = bus.cur_sec;
        cursor_d = FLD_HOUR;
        state_d  = ST_EDIT;
      end
      ST_EDIT: begin
        if (!bus.set_en) begin
          state_d = ST_COMMIT;
        end else begin
          // Edit uses the pre-move cursor; the cursor update below lands afterwards.
          if (bus.btn_up ^ bus.btn_down) begin
            accept = 1'b1;
            case (cursor_q)
              FLD_HOUR: hour_d = 5'(wrap_step(int'(hour_q), HOUR_MOD - 1, bus.btn_up));
              FLD_MIN:  min_d  = 6'(wrap_step(int'(min_q), MIN_SEC_MAX, bus.btn_up));
              FLD_SEC:  sec_d  = 6'(wrap_step(int'(sec_q), MIN_SEC_MAX, bus.btn_up));
              default: ;
            endcase
          end
          if (bus.btn_right && !bus.btn_left)      cursor_d = cursor_step(cursor_q, 1'b1);
          else if (bus.btn_left && !bus.btn_right) cursor_d = cursor_step(cursor_q, 1'b0);
`ifdef MFC_SET_TIMEOUT_EN
          if (btn_any)                                   idle_d  = '0;
          else if (idle_q == IW'(TIMEOUT_CYC - 1))       state_d = ST_ABORT;
          else                                           idle_d  = idle_q + IW'(1);
`endif
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
`ifdef MFC_SET_TIMEOUT_EN
      ST_ABORT: if (!bus.set_en) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_d = (state_q == ST_COMMIT);

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      cursor_q <= FLD_HOUR;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      cursor_q <= cursor_d;
      load_q   <= load_d;
    end
  end

`ifdef MFC_SET_TIMEOUT_EN
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  mfc_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk   (MCLK),
    .rst   (RST),
    .clr   ((state_q == ST_CAPTURE) || accept),
    .en    (state_q == ST_EDIT),
    .blink (blink_raw)
  );

  // The generator may tick on the exit edge; gating keeps blink dark outside EDIT.
  assign bus.blink      = blink_raw && (state_q == ST_EDIT);
  assign bus.set_active = (state_q == ST_EDIT);
  assign bus.edit_hour  = hour_q;
  assign bus.edit_min   = min_q;
  assign bus.edit_sec   = sec_q;
  assign bus.cursor     = cursor_q;
  assign bus.load       = load_q;
endmodule

// File: tb/tb_mfc_time_set_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_mfc_time_set_ctrl;
  localparam int BDIV = 8;
  localparam int TOUT = 64;
  localparam int HM   = 24;
  localparam int M_IDLE = 0, M_CAP = 1, M_EDIT = 2, M_COMMIT = 3, M_ABORT = 4;

  logic MCLK = 1'b0;
  logic RST  = 1'b1;
  mfc_time_set_ctrl_if bus();

  mfc_time_set_ctrl #(.BLINK_DIV(BDIV), .TIMEOUT_CYC(TOUT), .HOUR_MOD(HM)) dut (
    .MCLK (MCLK),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int fails  = 0;
  int loads_seen = 0;

  int m_mode, m_h, m_m, m_s, m_cur, m_bl, m_idle;
  bit m_load;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_h = 0; m_m = 0; m_s = 0; m_cur = 0; m_bl = 0; m_idle = 0; m_load = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit any, nxt_load;
    int d;
    any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
    nxt_load = (m_mode == M_COMMIT);
    case (m_mode)
      M_IDLE: if (bus.set_en) m_mode = M_CAP;
      M_CAP: begin
        m_h = bus.cur_hour; m_m = bus.cur_min; m_s = bus.cur_sec;
        m_cur = 0; m_bl = 0; m_idle = 0; m_mode = M_EDIT;
      end
      M_EDIT: begin
        if (!bus.set_en) begin
          m_mode = M_COMMIT;
        end else begin
          if (bus.btn_up != bus.btn_down) begin
            d = bus.btn_up ? 1 : -1;
            if (m_cur == 0)      m_h = (m_h + d + HM) % HM;
            else if (m_cur == 1) m_m = (m_m + d + 60) % 60;
            else                 m_s = (m_s + d + 60) % 60;
            m_bl = 0;
          end else begin
            m_bl++;
          end
          if (bus.btn_right != bus.btn_left) m_cur = (m_cur + (bus.btn_right ? 1 : 2)) % 3;
`ifdef MFC_SET_TIMEOUT_EN
          if (any) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == TOUT) m_mode = M_ABORT;
          end
`endif
        end
      end
      M_COMMIT: m_mode = M_IDLE;
      M_ABORT:  if (!bus.set_en) m_mode = M_IDLE;
      default:  m_mode = M_IDLE;
    endcase
    m_load = nxt_load;
    if (any && 1'b0) m_idle = m_idle; // keep 'any' referenced in the default build
  endtask

  task automatic compare();
    bit edit;
    edit = (m_mode == M_EDIT);
    chk("edit_hour", int'(bus.edit_hour), m_h);
    chk("edit_min", int'(bus.edit_min), m_m);
    chk("edit_sec", int'(bus.edit_sec), m_s);
    chk("cursor", int'(bus.cursor), m_cur);
    chk("set_active", int'(bus.set_active), int'(edit));
    chk("blink", int'(bus.blink), (edit && ((m_bl / BDIV) % 2 == 1)) ? 1 : 0);
    chk("load", int'(bus.load), int'(m_load));
    if (bus.load === 1'b1) loads_seen++;
  endtask

  task automatic tick(input bit se, input bit u, input bit dn, input bit l, input bit r);
    bus.set_en = se; bus.btn_up = u; bus.btn_down = dn; bus.btn_left = l; bus.btn_right = r;
    model_step();
    @(negedge MCLK);
    compare();
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hour = 5'(h); bus.cur_min = 6'(m); bus.cur_sec = 6'(s);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    model_reset();
    @(negedge MCLK);
    compare();
    bus.set_en = 1'b0;
    RST = 1'b0;
  endtask

  int l0;
  bit se_r;

  initial begin
    bus.set_en = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    set_cur(0, 0, 0);
    model_reset();
    repeat (3) @(negedge MCLK);
    compare();
    chk("rst_set_active", int'(bus.set_active), 0);
    chk("rst_load", int'(bus.load), 0);
    RST = 1'b0;

    // 1. buttons ignored in IDLE
    set_cur(5, 6, 7);
    tick(0, 1, 0, 0, 1);
    tick(0, 0, 1, 1, 0);
    chk("idle_hour", int'(bus.edit_hour), 0);
    chk("idle_cursor", int'(bus.cursor), 0);

    // 2. capture and hour wrap
    set_cur(23, 59, 58);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("cap_hour", int'(bus.edit_hour), 23);
    chk("cap_sec", int'(bus.edit_sec), 58);
    chk("cap_active", int'(bus.set_active), 1);
    set_cur(1, 2, 3);
    tick(1, 1, 0, 0, 0);
    chk("hour_up_wrap", int'(bus.edit_hour), 0);
    tick(1, 0, 1, 0, 0);
    chk("hour_down_wrap", int'(bus.edit_hour), 23);

    // 3. cursor moves and second wrap
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    chk("cursor_sec", int'(bus.cursor), 2);
    tick(1, 1, 0, 0, 0);
    chk("sec_59", int'(bus.edit_sec), 59);
    tick(1, 1, 0, 0, 0);
    chk("sec_wrap", int'(bus.edit_sec), 0);
    tick(1, 0, 0, 0, 1);
    chk("cursor_wrap_r", int'(bus.cursor), 0);
    tick(1, 0, 0, 1, 0);
    chk("cursor_wrap_l", int'(bus.cursor), 2);

    // 4. edit to 12:34:00 and commit
    tick(1, 0, 0, 0, 1);
    repeat (11) tick(1, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 1);
    repeat (25) tick(1, 0, 1, 0, 0);
    chk("pre_hour", int'(bus.edit_hour), 12);
    chk("pre_min", int'(bus.edit_min), 34);
    chk("pre_sec", int'(bus.edit_sec), 0);
    l0 = loads_seen;
    tick(0, 0, 0, 0, 0);
    chk("load_lat1", int'(bus.load), 0);
    tick(0, 0, 0, 0, 0);
    chk("load_lat2", int'(bus.load), 1);
    chk("load_min", int'(bus.edit_min), 34);
    tick(0, 0, 0, 0, 0);
    chk("load_once", loads_seen - l0, 1);
    chk("post_active", int'(bus.set_active), 0);

    // 5. simultaneous up/down, then reset mid-edit
    set_cur(7, 8, 9);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    chk("updown_hold", int'(bus.edit_hour), 7);
    l0 = loads_seen;
    pulse_reset();
    chk("rst_mid_hour", int'(bus.edit_hour), 0);
    repeat (4) tick(0, 0, 0, 0, 0);
    chk("rst_no_load", loads_seen - l0, 0);

    // 6. idle timeout (or persistence without it)
    set_cur(1, 2, 3);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    repeat (70) tick(1, 0, 0, 0, 0);
    l0 = loads_seen;
`ifdef MFC_SET_TIMEOUT_EN
    chk("timeout_active", int'(bus.set_active), 0);
`else
    chk("timeout_active", int'(bus.set_active), 1);
`endif
    repeat (4) tick(0, 0, 0, 0, 0);
`ifdef MFC_SET_TIMEOUT_EN
    chk("timeout_loads", loads_seen - l0, 0);
`else
    chk("timeout_loads", loads_seen - l0, 1);
`endif

    // Random phase
    se_r = 0;
    for (int i = 0; i < 3000; i++) begin
      set_cur(int'($urandom_range(0, HM - 1)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      if ($urandom_range(0, 39) == 0) se_r = ~se_r;
      if ($urandom_range(0, 799) == 0) pulse_reset();
      else if (i % 400 < 100)
        tick(se_r, 0, 0, 0, 0);
      else
        tick(se_r, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
